// File: rtl/z_result_writeback.sv
// ALU result writeback: captures {Chigh, Clow} into Z and streams it onto the bus as one or two beats.
// Optional zero/negative status flags are built when Z_STATUS_EN is defined.
module z_result_writeback #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] Chigh,
    input  logic [WIDTH-1:0] Clow,
    input  logic             Zin,
    input  logic             wide,
    input  logic             bus_ready,
    output logic [WIDTH-1:0] bus_data,
    output logic             bus_valid,
    output logic             rf_we,
    output logic             lo_we,
    output logic             hi_we,
    output logic             busy,
    output logic [WIDTH-1:0] zhigh_q,
    output logic [WIDTH-1:0] zlow_q,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q,
    output logic             cap_drop,
    output logic             z_flag,
    output logic             n_flag
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LO_BEAT = 2'd1,
        HI_BEAT = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             wide_q;
    logic             wide_d;
    logic [WIDTH-1:0] zhigh_d;
    logic [WIDTH-1:0] zlow_d;
    logic             last_beat;
    logic             capture;

    // Next state; a capture on the final accepted beat chains straight into LO_BEAT.
    always_comb begin
        state_d   = state_q;
        last_beat = bus_ready && ((state_q == HI_BEAT) || ((state_q == LO_BEAT) && !wide_q));
        capture   = Zin && ((state_q == IDLE) || last_beat);
        case (state_q)
            IDLE: begin
                if (capture) state_d = LO_BEAT;
            end
            LO_BEAT: begin
                if (bus_ready) begin
                    if (wide_q)       state_d = HI_BEAT;
                    else if (capture) state_d = LO_BEAT;
                    else              state_d = IDLE;
                end
            end
            HI_BEAT: begin
                if (bus_ready) state_d = capture ? LO_BEAT : IDLE;
            end
            default: state_d = IDLE;
        endcase
        wide_d  = capture ? wide  : wide_q;
        zhigh_d = capture ? Chigh : zhigh_q;
        zlow_d  = capture ? Clow  : zlow_q;
    end

    // State, Z/HI/LO and the beat outputs, which are registered from the next state.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= IDLE;
            wide_q    <= 1'b0;
            zhigh_q   <= '0;
            zlow_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cap_drop  <= 1'b0;
            busy      <= 1'b0;
            bus_valid <= 1'b0;
            bus_data  <= '0;
            rf_we     <= 1'b0;
            lo_we     <= 1'b0;
            hi_we     <= 1'b0;
        end else begin
            state_q <= state_d;
            wide_q  <= wide_d;
            zhigh_q <= zhigh_d;
            zlow_q  <= zlow_d;
            if ((state_q == LO_BEAT) && bus_ready && wide_q) lo_q <= zlow_q;
            if ((state_q == HI_BEAT) && bus_ready)           hi_q <= zhigh_q;
            if (Zin && !capture && (state_q != IDLE))        cap_drop <= 1'b1;
            busy      <= (state_d != IDLE);
            bus_valid <= (state_d != IDLE);
            case (state_d)
                LO_BEAT: bus_data <= zlow_d;
                HI_BEAT: bus_data <= zhigh_d;
                default: bus_data <= '0;
            endcase
            rf_we <= (state_d == LO_BEAT) && !wide_d;
            lo_we <= (state_d == LO_BEAT) && wide_d;
            hi_we <= (state_d == HI_BEAT);
        end
    end

`ifdef Z_STATUS_EN
    // Status flags follow the most recent capture.
    always_ff @(posedge clock) begin
        if (clear) begin
            z_flag <= 1'b0;
            n_flag <= 1'b0;
        end else if (capture) begin
            z_flag <= wide ? ({Chigh, Clow} == '0) : (Clow == '0);
            n_flag <= wide ? Chigh[WIDTH-1] : Clow[WIDTH-1];
        end
    end
`else
    assign z_flag = 1'b0;
    assign n_flag = 1'b0;
`endif

endmodule
